// File: rtl/ifm_row_ring_manager_pkg.sv
// Shared types for the IFM row ring manager: per-buffer lifecycle states
// and default sizing used by the top level and its slot sub-module.
package ifm_row_ring_manager_pkg;

   typedef enum logic [1:0] {
      BUF_EMPTY   = 2'd0,
      BUF_LOADING = 2'd1,
      BUF_READY   = 2'd2,
      BUF_IN_USE  = 2'd3
   } buf_state_e;

   localparam int DEF_W_SIZE      = 10;
   localparam int DEF_IFM_BUF_CNT = 4;
   localparam int DEF_W_IFM_BUF   = 2;
   localparam int DEF_K_ROWS      = 3;

endpackage

// File: rtl/ifm_row_ring_manager_slot.sv
// One IFM row buffer slot: tracks the buffer lifecycle state and the row
// index currently held. Commands from the top are only honoured in the
// state where they make sense, so stray pulses are harmless.
module ifm_row_ring_manager_slot
   import ifm_row_ring_manager_pkg::*;
#(
   parameter int W_SIZE = DEF_W_SIZE
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              load_i,
   input  logic [W_SIZE-1:0] row_i,
   input  logic              done_i,
   input  logic              grant_i,
   input  logic              free_i,
   input  logic              keep_i,
   output buf_state_e        state_o,
   output logic [W_SIZE-1:0] row_o
);

   buf_state_e        state_q, state_d;
   logic [W_SIZE-1:0] row_q;

   // Next lifecycle state; each command only applies in its source state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BUF_EMPTY:   if (load_i)  state_d = BUF_LOADING;
         BUF_LOADING: if (done_i)  state_d = BUF_READY;
         BUF_READY:   if (grant_i) state_d = BUF_IN_USE;
         BUF_IN_USE: begin
            if (free_i)      state_d = BUF_EMPTY;
            else if (keep_i) state_d = BUF_READY;
         end
         default:     state_d = BUF_EMPTY;
      endcase
   end

   // State and captured row index; the row is latched when a load starts
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= BUF_EMPTY;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         if (load_i && (state_q == BUF_EMPTY)) row_q <= row_i;
      end
   end

   assign state_o = state_q;
   assign row_o   = row_q;

endmodule

// File: rtl/ifm_row_ring_manager.sv
// IFM row ring manager: dispatches row loads to the ring tail, tracks load
// completion and grants conv_pe a window of K_ROWS consecutive ready rows
// starting at the ring head, released with stride 1 or 2.
// Optional macro IFM_BUF_ERR_EN adds a sticky protocol-error output o_err.
module ifm_row_ring_manager
   import ifm_row_ring_manager_pkg::*;
#(
   parameter int W_SIZE      = DEF_W_SIZE,
   parameter int IFM_BUF_CNT = DEF_IFM_BUF_CNT,
   parameter int W_IFM_BUF   = DEF_W_IFM_BUF,
   parameter int K_ROWS      = DEF_K_ROWS
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   m_req_load,
   input  logic [W_SIZE-1:0]      m_req_row,
   output logic                   o_req_ready,
   output logic                   o_req_done,
   input  logic [IFM_BUF_CNT-1:0] m_buf_done,
   output logic [IFM_BUF_CNT-1:0] o_buf_sel,
   output logic [W_SIZE-1:0]      o_buf_row,
   input  logic                   m_win_req,
   input  logic                   m_win_release,
   input  logic                   m_release_stride,
   output logic                   o_win_valid,
   output logic [W_IFM_BUF-1:0]   o_win_base,
   output logic [W_SIZE-1:0]      o_win_row,
   output logic [W_IFM_BUF:0]     o_cnt,
   output logic                   o_full,
   output logic                   o_empty
`ifdef IFM_BUF_ERR_EN
   ,
   output logic                   o_err
`endif
);

   buf_state_e        slotState [IFM_BUF_CNT];
   logic [W_SIZE-1:0] slotRow   [IFM_BUF_CNT];

   logic [W_IFM_BUF-1:0]   head_q, tail_q;
   logic                   winActive_q;
   logic [IFM_BUF_CNT-1:0] bufSel_q;
   logic [W_SIZE-1:0]      bufRow_q;
   logic                   reqDone_q;
   logic [W_IFM_BUF:0]     cnt_q, cnt_d;
   logic                   full_q, empty_q;

   logic                   accept, grant, release_w, winReady;
   logic [IFM_BUF_CNT-1:0] inWin, inFree, loadingMask;
   logic [W_IFM_BUF:0]     relLen;
   logic [W_IFM_BUF-1:0]   offset;

   assign o_req_ready = (slotState[tail_q] == BUF_EMPTY);
   assign accept      = m_req_load && o_req_ready;
   assign release_w   = m_win_release && winActive_q;
   assign o_win_valid = !winActive_q && winReady;
   assign grant       = m_win_req && o_win_valid;
   assign relLen      = (m_release_stride && (K_ROWS >= 2)) ? (W_IFM_BUF+1)'(2) : (W_IFM_BUF+1)'(1);

   // Window and release masks by ring distance from head, plus readiness
   always_comb begin
      inWin       = '0;
      inFree      = '0;
      loadingMask = '0;
      winReady    = 1'b1;
      offset      = '0;
      for (int i = 0; i < IFM_BUF_CNT; i++) begin
         offset         = W_IFM_BUF'(i) - head_q;
         inWin[i]       = (32'(offset) < 32'(K_ROWS));
         inFree[i]      = ({1'b0, offset} < relLen);
         loadingMask[i] = (slotState[i] == BUF_LOADING);
         if (inWin[i] && (slotState[i] != BUF_READY)) winReady = 1'b0;
      end
   end

   // Occupancy after this edge: one more per accept, fewer by the freed rows
   always_comb begin
      cnt_d = cnt_q + (W_IFM_BUF+1)'(accept);
      if (release_w) cnt_d = cnt_d - relLen;
   end

   for (genvar g = 0; g < IFM_BUF_CNT; g++) begin : gSlot
      ifm_row_ring_manager_slot #(.W_SIZE(W_SIZE)) uSlot (
         .clk     (clk),
         .rstn    (rstn),
         .load_i  (accept && (tail_q == W_IFM_BUF'(g))),
         .row_i   (m_req_row),
         .done_i  (m_buf_done[g]),
         .grant_i (grant && inWin[g]),
         .free_i  (release_w && inFree[g]),
         .keep_i  (release_w && inWin[g] && !inFree[g]),
         .state_o (slotState[g]),
         .row_o   (slotRow[g])
      );
   end

   // Ring pointers, window ownership and registered status outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_q      <= '0;
         tail_q      <= '0;
         winActive_q <= 1'b0;
         bufSel_q    <= '0;
         bufRow_q    <= '0;
         reqDone_q   <= 1'b0;
         cnt_q       <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
      end else begin
         if (accept) tail_q <= tail_q + W_IFM_BUF'(1);
         if (release_w) begin
            head_q      <= head_q + relLen[W_IFM_BUF-1:0];
            winActive_q <= 1'b0;
         end else if (grant) begin
            winActive_q <= 1'b1;
         end
         bufSel_q  <= accept ? (IFM_BUF_CNT'(1) << tail_q) : '0;
         bufRow_q  <= accept ? m_req_row : '0;
         reqDone_q <= |(m_buf_done & loadingMask);
         cnt_q     <= cnt_d;
         full_q    <= (cnt_d == (W_IFM_BUF+1)'(IFM_BUF_CNT));
         empty_q   <= (cnt_d == '0);
      end
   end

`ifdef IFM_BUF_ERR_EN
   logic err_q;

   // Sticky flag for stray dones, loads into a busy tail and orphan releases
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_q <= 1'b0;
      end else if ((|(m_buf_done & ~loadingMask)) ||
                   (m_req_load && !o_req_ready) ||
                   (m_win_release && !winActive_q)) begin
         err_q <= 1'b1;
      end
   end

   assign o_err = err_q;
`endif

   assign o_buf_sel  = bufSel_q;
   assign o_buf_row  = bufRow_q;
   assign o_req_done = reqDone_q;
   assign o_win_base = head_q;
   assign o_win_row  = slotRow[head_q];
   assign o_cnt      = cnt_q;
   assign o_full     = full_q;
   assign o_empty    = empty_q;

endmodule

// File: tb/tb_ifm_row_ring_manager.sv
// Directed bench for ifm_row_ring_manager (default sizing: 4 buffers,
// 3-row window). Define IFM_BUF_ERR_EN to also exercise o_err.
module tb_ifm_row_ring_manager;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       m_req_load = 1'b0;
   logic [9:0] m_req_row = '0;
   logic       o_req_ready, o_req_done;
   logic [3:0] m_buf_done = '0;
   logic [3:0] o_buf_sel;
   logic [9:0] o_buf_row;
   logic       m_win_req = 1'b0, m_win_release = 1'b0, m_release_stride = 1'b0;
   logic       o_win_valid;
   logic [1:0] o_win_base;
   logic [9:0] o_win_row;
   logic [2:0] o_cnt;
   logic       o_full, o_empty;
`ifdef IFM_BUF_ERR_EN
   logic       o_err;
`endif

   int tests = 0;
   int failed = 0;

   ifm_row_ring_manager dut (
      .clk(clk), .rstn(rstn),
      .m_req_load(m_req_load), .m_req_row(m_req_row),
      .o_req_ready(o_req_ready), .o_req_done(o_req_done),
      .m_buf_done(m_buf_done), .o_buf_sel(o_buf_sel), .o_buf_row(o_buf_row),
      .m_win_req(m_win_req), .m_win_release(m_win_release),
      .m_release_stride(m_release_stride),
      .o_win_valid(o_win_valid), .o_win_base(o_win_base), .o_win_row(o_win_row),
      .o_cnt(o_cnt), .o_full(o_full), .o_empty(o_empty)
`ifdef IFM_BUF_ERR_EN
      , .o_err(o_err)
`endif
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Advance one active edge and settle just past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      tick();
      tests++; if (o_buf_sel !== 4'b0000) begin failed++; $display("[TB] FAIL rst_sel: got %b expected 0000", o_buf_sel); end
      tests++; if (o_buf_row !== 10'd0) begin failed++; $display("[TB] FAIL rst_row: got %0d expected 0", o_buf_row); end
      tests++; if (o_req_done !== 1'b0) begin failed++; $display("[TB] FAIL rst_done: got %b expected 0", o_req_done); end
      tests++; if (o_cnt !== 3'd0) begin failed++; $display("[TB] FAIL rst_cnt: got %0d expected 0", o_cnt); end
      tests++; if (o_empty !== 1'b1 || o_full !== 1'b0) begin failed++; $display("[TB] FAIL rst_flags: got empty=%b full=%b expected 1/0", o_empty, o_full); end
      tests++; if (o_win_valid !== 1'b0 || o_win_base !== 2'd0 || o_win_row !== 10'd0) begin failed++; $display("[TB] FAIL rst_win: got v=%b base=%0d row=%0d expected 0/0/0", o_win_valid, o_win_base, o_win_row); end
      tests++; if (o_req_ready !== 1'b1) begin failed++; $display("[TB] FAIL rst_ready: got %b expected 1", o_req_ready); end
`ifdef IFM_BUF_ERR_EN
      tests++; if (o_err !== 1'b0) begin failed++; $display("[TB] FAIL rst_err: got %b expected 0", o_err); end
`endif
      rstn = 1'b1;
   endtask

   task automatic test_loads();
      logic [3:0] expSel;
      for (int i = 0; i < 4; i++) begin
         m_req_load = 1'b1;
         m_req_row  = 10'(i);
         tests++; if (o_req_ready !== 1'b1) begin failed++; $display("[TB] FAIL load%0d_ready: got %b expected 1", i, o_req_ready); end
         tick();
         expSel = 4'b0001 << i;
         tests++; if (o_buf_sel !== expSel) begin failed++; $display("[TB] FAIL load%0d_sel: got %b expected %b", i, o_buf_sel, expSel); end
         tests++; if (o_buf_row !== 10'(i)) begin failed++; $display("[TB] FAIL load%0d_row: got %0d expected %0d", i, o_buf_row, i); end
         tests++; if (o_cnt !== 3'(i + 1)) begin failed++; $display("[TB] FAIL load%0d_cnt: got %0d expected %0d", i, o_cnt, i + 1); end
      end
      m_req_load = 1'b0;
      tests++; if (o_full !== 1'b1 || o_empty !== 1'b0) begin failed++; $display("[TB] FAIL full_flags: got full=%b empty=%b expected 1/0", o_full, o_empty); end
      tests++; if (o_req_ready !== 1'b0) begin failed++; $display("[TB] FAIL fifth_ready: got %b expected 0", o_req_ready); end
      tests++; if (o_win_valid !== 1'b0) begin failed++; $display("[TB] FAIL loading_winvalid: got %b expected 0", o_win_valid); end
      tick();
      tests++; if (o_buf_sel !== 4'b0000) begin failed++; $display("[TB] FAIL sel_pulse: got %b expected 0000", o_buf_sel); end
   endtask

   task automatic test_done_window();
      m_buf_done = 4'b0111;
      tick();
      m_buf_done = 4'b0000;
      tests++; if (o_req_done !== 1'b1) begin failed++; $display("[TB] FAIL done_pulse: got %b expected 1", o_req_done); end
      tests++; if (o_win_valid !== 1'b1) begin failed++; $display("[TB] FAIL done_winvalid: got %b expected 1", o_win_valid); end
      tests++; if (o_win_base !== 2'd0 || o_win_row !== 10'd0) begin failed++; $display("[TB] FAIL done_head: got base=%0d row=%0d expected 0/0", o_win_base, o_win_row); end
      tick();
      tests++; if (o_req_done !== 1'b0) begin failed++; $display("[TB] FAIL done_single: got %b expected 0", o_req_done); end
   endtask

   task automatic test_release_stride1();
      m_win_req = 1'b1;
      tick();
      m_win_req = 1'b0;
      tests++; if (o_win_valid !== 1'b0) begin failed++; $display("[TB] FAIL grant_winvalid: got %b expected 0", o_win_valid); end
      tests++; if (o_cnt !== 3'd4) begin failed++; $display("[TB] FAIL grant_cnt: got %0d expected 4", o_cnt); end
      m_win_release    = 1'b1;
      m_release_stride = 1'b0;
      tick();
      m_win_release = 1'b0;
      tests++; if (o_cnt !== 3'd3 || o_full !== 1'b0) begin failed++; $display("[TB] FAIL rel1_cnt: got cnt=%0d full=%b expected 3/0", o_cnt, o_full); end
      tests++; if (o_win_base !== 2'd1 || o_win_row !== 10'd1) begin failed++; $display("[TB] FAIL rel1_head: got base=%0d row=%0d expected 1/1", o_win_base, o_win_row); end
      tests++; if (o_req_ready !== 1'b1) begin failed++; $display("[TB] FAIL rel1_ready: got %b expected 1", o_req_ready); end
      tests++; if (o_win_valid !== 1'b0) begin failed++; $display("[TB] FAIL rel1_winvalid: got %b expected 0", o_win_valid); end
      m_req_load = 1'b1;
      m_req_row  = 10'd4;
      tick();
      m_req_load = 1'b0;
      tests++; if (o_buf_sel !== 4'b0001 || o_buf_row !== 10'd4) begin failed++; $display("[TB] FAIL wrap_load: got sel=%b row=%0d expected 0001/4", o_buf_sel, o_buf_row); end
      tests++; if (o_cnt !== 3'd4 || o_req_ready !== 1'b0) begin failed++; $display("[TB] FAIL wrap_cnt: got cnt=%0d ready=%b expected 4/0", o_cnt, o_req_ready); end
   endtask

   task automatic test_release_stride2();
      m_buf_done = 4'b1001;
      tick();
      m_buf_done = 4'b0000;
      tests++; if (o_win_valid !== 1'b1) begin failed++; $display("[TB] FAIL s2a_winvalid: got %b expected 1", o_win_valid); end
      m_win_req = 1'b1;
      tick();
      m_win_req        = 1'b0;
      m_win_release    = 1'b1;
      m_release_stride = 1'b1;
      tick();
      m_win_release = 1'b0;
      tests++; if (o_win_base !== 2'd3 || o_win_row !== 10'd3) begin failed++; $display("[TB] FAIL s2a_head: got base=%0d row=%0d expected 3/3", o_win_base, o_win_row); end
      tests++; if (o_cnt !== 3'd2) begin failed++; $display("[TB] FAIL s2a_cnt: got %0d expected 2", o_cnt); end
      tests++; if (o_win_valid !== 1'b0) begin failed++; $display("[TB] FAIL s2a_gap: got %b expected 0", o_win_valid); end
      m_req_load = 1'b1;
      m_req_row  = 10'd5;
      tick();
      m_req_load = 1'b0;
      tests++; if (o_buf_sel !== 4'b0010) begin failed++; $display("[TB] FAIL s2_load_sel: got %b expected 0010", o_buf_sel); end
      m_buf_done = 4'b0010;
      tick();
      m_buf_done = 4'b0000;
      tests++; if (o_win_valid !== 1'b1) begin failed++; $display("[TB] FAIL s2b_winvalid: got %b expected 1", o_win_valid); end
      m_win_req = 1'b1;
      tick();
      m_win_req     = 1'b0;
      m_win_release = 1'b1;
      tick();
      m_win_release    = 1'b0;
      m_release_stride = 1'b0;
      tests++; if (o_win_base !== 2'd1 || o_win_row !== 10'd5) begin failed++; $display("[TB] FAIL s2b_wrap: got base=%0d row=%0d expected 1/5", o_win_base, o_win_row); end
      tests++; if (o_cnt !== 3'd1) begin failed++; $display("[TB] FAIL s2b_cnt: got %0d expected 1", o_cnt); end
   endtask

   task automatic test_errors();
`ifdef IFM_BUF_ERR_EN
      tests++; if (o_err !== 1'b0) begin failed++; $display("[TB] FAIL err_clean: got %b expected 0", o_err); end
`endif
      m_win_release = 1'b1;
      tick();
      m_win_release = 1'b0;
      tests++; if (o_cnt !== 3'd1 || o_win_base !== 2'd1) begin failed++; $display("[TB] FAIL orphan_rel: got cnt=%0d base=%0d expected 1/1", o_cnt, o_win_base); end
`ifdef IFM_BUF_ERR_EN
      tests++; if (o_err !== 1'b1) begin failed++; $display("[TB] FAIL err_rel: got %b expected 1", o_err); end
`endif
      m_buf_done = 4'b0001;
      tick();
      m_buf_done = 4'b0000;
      tests++; if (o_req_done !== 1'b0 || o_cnt !== 3'd1) begin failed++; $display("[TB] FAIL stray_done: got done=%b cnt=%0d expected 0/1", o_req_done, o_cnt); end
      tests++; if (o_req_ready !== 1'b1) begin failed++; $display("[TB] FAIL stray_ready: got %b expected 1", o_req_ready); end
`ifdef IFM_BUF_ERR_EN
      tests++; if (o_err !== 1'b1) begin failed++; $display("[TB] FAIL err_sticky: got %b expected 1", o_err); end
`endif
   endtask

   task automatic test_reset_midop();
      m_req_load = 1'b1;
      m_req_row  = 10'd8;
      tick();
      m_req_row  = 10'd9;
      tick();
      m_req_load = 1'b0;
      tests++; if (o_cnt !== 3'd3) begin failed++; $display("[TB] FAIL mid_cnt: got %0d expected 3", o_cnt); end
      #2;
      rstn = 1'b0;
      #1;
      tests++; if (o_cnt !== 3'd0 || o_empty !== 1'b1 || o_full !== 1'b0) begin failed++; $display("[TB] FAIL mid_rst_cnt: got cnt=%0d empty=%b full=%b expected 0/1/0", o_cnt, o_empty, o_full); end
      tests++; if (o_buf_sel !== 4'b0000 || o_buf_row !== 10'd0 || o_req_done !== 1'b0) begin failed++; $display("[TB] FAIL mid_rst_out: got sel=%b row=%0d done=%b expected 0000/0/0", o_buf_sel, o_buf_row, o_req_done); end
      tests++; if (o_win_base !== 2'd0 || o_win_row !== 10'd0 || o_win_valid !== 1'b0) begin failed++; $display("[TB] FAIL mid_rst_win: got base=%0d row=%0d v=%b expected 0/0/0", o_win_base, o_win_row, o_win_valid); end
`ifdef IFM_BUF_ERR_EN
      tests++; if (o_err !== 1'b0) begin failed++; $display("[TB] FAIL mid_rst_err: got %b expected 0", o_err); end
`endif
      tick();
      rstn = 1'b1;
      m_buf_done = 4'b1100;
      tick();
      m_buf_done = 4'b0000;
      tests++; if (o_empty !== 1'b1 || o_cnt !== 3'd0) begin failed++; $display("[TB] FAIL late_done_empty: got empty=%b cnt=%0d expected 1/0", o_empty, o_cnt); end
      tests++; if (o_req_done !== 1'b0 || o_win_valid !== 1'b0) begin failed++; $display("[TB] FAIL late_done_out: got done=%b v=%b expected 0/0", o_req_done, o_win_valid); end
   endtask

   // Scenarios run back to back; each leaves the ring in a known state
   initial begin
      test_reset();
      test_loads();
      test_done_window();
      test_release_stride1();
      test_release_stride2();
      test_errors();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
